// File: rtl/mem_channel_arbiter.sv
// Multiplexes per-consumer cache fill reads and eviction writes onto NUM_CHANNELS
// memory channels, each running its own request/wait/relay FSM with round-robin grants.
module mem_channel_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 8,
    parameter int unsigned NUM_CHANNELS  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int unsigned CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        READ_RELAY,
        WRITE_RELAY
    } state_e;

    state_e                           state_q [NUM_CHANNELS];
    state_e                           state_d [NUM_CHANNELS];
    logic [CW-1:0]                    owner_q [NUM_CHANNELS];
    logic [CW-1:0]                    owner_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]         claimed_q, claimed_d;
    logic [CW-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [NUM_CHANNELS-1:0]          mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0]          mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address_q, mem_write_address_d;
    logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]         consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0]         consumer_write_ready_q, consumer_write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;

    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic                     granted;
    logic [CW-1:0]            sel;
    logic [CW-1:0]            last_sel;

    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        claimed_d              = claimed_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_write_ready_d = consumer_write_ready_q;
        consumer_read_data_d   = consumer_read_data_q;
        // Grants only see claims from the previous cycle; lower channels add to
        // 'taken' so a consumer gets at most one channel per cycle.
        taken    = claimed_q;
        found    = 1'b0;
        granted  = 1'b0;
        sel      = '0;
        last_sel = '0;

        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                IDLE: begin
                    found = 1'b0;
                    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                        sel = CW'((32'(rr_ptr_q) + k) % NUM_CONSUMERS);
                        if (!found && !taken[sel] &&
                            (consumer_read_valid[sel] || consumer_write_valid[sel])) begin
                            found          = 1'b1;
                            granted        = 1'b1;
                            last_sel       = sel;
                            taken[sel]     = 1'b1;
                            claimed_d[sel] = 1'b1;
                            owner_d[ch]    = sel;
                            if (consumer_read_valid[sel]) begin
                                state_d[ch]          = READ_WAIT;
                                mem_read_valid_d[ch] = 1'b1;
                                mem_read_address_d[ch*ADDR_BITS +: ADDR_BITS] =
                                    consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
                            end else begin
                                state_d[ch]           = WRITE_WAIT;
                                mem_write_valid_d[ch] = 1'b1;
                                mem_write_address_d[ch*ADDR_BITS +: ADDR_BITS] =
                                    consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
                                mem_write_data_d[ch*DATA_BITS +: DATA_BITS] =
                                    consumer_write_data[sel*DATA_BITS +: DATA_BITS];
                            end
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        state_d[ch]                           = READ_RELAY;
                        mem_read_valid_d[ch]                  = 1'b0;
                        consumer_read_ready_d[owner_q[ch]]    = 1'b1;
                        consumer_read_data_d[owner_q[ch]*DATA_BITS +: DATA_BITS] =
                            mem_read_data[ch*DATA_BITS +: DATA_BITS];
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        state_d[ch]                         = WRITE_RELAY;
                        mem_write_valid_d[ch]               = 1'b0;
                        consumer_write_ready_d[owner_q[ch]] = 1'b1;
                    end
                end
                READ_RELAY: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        state_d[ch]                        = IDLE;
                        consumer_read_ready_d[owner_q[ch]] = 1'b0;
                        claimed_d[owner_q[ch]]             = 1'b0;
                    end
                end
                WRITE_RELAY: begin
                    if (!consumer_write_valid[owner_q[ch]]) begin
                        state_d[ch]                         = IDLE;
                        consumer_write_ready_d[owner_q[ch]] = 1'b0;
                        claimed_d[owner_q[ch]]              = 1'b0;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end

        rr_ptr_d = granted ? CW'((32'(last_sel) + 1) % NUM_CONSUMERS) : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                owner_q[ch] <= '0;
            end
            claimed_q              <= '0;
            rr_ptr_q               <= '0;
            mem_read_valid_q       <= '0;
            mem_write_valid_q      <= '0;
            mem_read_address_q     <= '0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_write_ready_q <= '0;
            consumer_read_data_q   <= '0;
        end else begin
            state_q                <= state_d;
            owner_q                <= owner_d;
            claimed_q              <= claimed_d;
            rr_ptr_q               <= rr_ptr_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_write_ready_q <= consumer_write_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
        end
    end

    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign consumer_write_ready = consumer_write_ready_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Randomized bench for mem_channel_arbiter: consumer agents and a memory responder
// drive the DUT while a transaction-level model predicts every output each cycle.
module tb_mem_channel_arbiter;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 8;
    localparam int NCH = 4;
    localparam int NUM_CYCLES = 4000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NC-1:0]     crv, cwv, crr, cwr;
    logic [NC*AB-1:0]  cra, cwa;
    logic [NC*DB-1:0]  cwd, crd;
    logic [NCH-1:0]    mrv, mwv, mrr, mwr;
    logic [NCH*AB-1:0] mra, mwa;
    logic [NCH*DB-1:0] mrd, mwd;

    mem_channel_arbiter #(
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB),
        .NUM_CONSUMERS(NC),
        .NUM_CHANNELS (NCH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (crv),
        .consumer_read_address (cra),
        .consumer_read_ready   (crr),
        .consumer_read_data    (crd),
        .consumer_write_valid  (cwv),
        .consumer_write_address(cwa),
        .consumer_write_data   (cwd),
        .consumer_write_ready  (cwr),
        .mem_read_valid        (mrv),
        .mem_read_address      (mra),
        .mem_read_ready        (mrr),
        .mem_read_data         (mrd),
        .mem_write_valid       (mwv),
        .mem_write_address     (mwa),
        .mem_write_data        (mwd),
        .mem_write_ready       (mwr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] mem_hash(input logic [7:0] a);
        return (a * 8'd3) ^ 8'h5A;
    endfunction

    // Reference model: each channel holds at most one transaction record; grants
    // pair free channels (ascending) with waiting consumers in round-robin order.
    bit m_busy [NCH];
    bit m_rd   [NCH];
    bit m_ack  [NCH];
    int m_own  [NCH];
    bit m_claim [NC];
    int m_rr;
    logic [NCH-1:0]    e_mrv, e_mwv;
    logic [NCH*AB-1:0] e_mra, e_mwa;
    logic [NCH*DB-1:0] e_mwd;
    logic [NC-1:0]     e_crr, e_cwr;
    logic [NC*DB-1:0]  e_crd;

    task automatic model_step();
        bit ob [NCH];
        bit oc [NC];
        int cand [$];
        int fr [$];
        int c, ch, n;
        if (reset) begin
            for (int i = 0; i < NCH; i++) m_busy[i] = 1'b0;
            for (int i = 0; i < NC; i++) m_claim[i] = 1'b0;
            m_rr = 0;
            e_mrv = '0; e_mwv = '0; e_mra = '0; e_mwa = '0; e_mwd = '0;
            e_crr = '0; e_cwr = '0; e_crd = '0;
            return;
        end
        ob = m_busy;
        oc = m_claim;
        for (int i = 0; i < NCH; i++) begin
            if (m_busy[i]) begin
                c = m_own[i];
                if (!m_ack[i]) begin
                    if (m_rd[i] ? mrr[i] : mwr[i]) begin
                        m_ack[i] = 1'b1;
                        if (m_rd[i]) begin
                            e_mrv[i] = 1'b0;
                            e_crr[c] = 1'b1;
                            e_crd[c*DB +: DB] = mrd[i*DB +: DB];
                        end else begin
                            e_mwv[i] = 1'b0;
                            e_cwr[c] = 1'b1;
                        end
                    end
                end else if (!(m_rd[i] ? crv[c] : cwv[c])) begin
                    m_busy[i]  = 1'b0;
                    m_claim[c] = 1'b0;
                    if (m_rd[i]) e_crr[c] = 1'b0;
                    else         e_cwr[c] = 1'b0;
                end
            end
        end
        for (int j = 0; j < NC; j++) begin
            c = (m_rr + j) % NC;
            if ((crv[c] || cwv[c]) && !oc[c]) cand.push_back(c);
        end
        for (int i = 0; i < NCH; i++) if (!ob[i]) fr.push_back(i);
        n = (cand.size() < fr.size()) ? cand.size() : fr.size();
        for (int i = 0; i < n; i++) begin
            ch = fr[i];
            c  = cand[i];
            m_busy[ch] = 1'b1;
            m_own[ch]  = c;
            m_ack[ch]  = 1'b0;
            m_rd[ch]   = crv[c];
            m_claim[c] = 1'b1;
            if (crv[c]) begin
                e_mrv[ch] = 1'b1;
                e_mra[ch*AB +: AB] = cra[c*AB +: AB];
            end else begin
                e_mwv[ch] = 1'b1;
                e_mwa[ch*AB +: AB] = cwa[c*AB +: AB];
                e_mwd[ch*DB +: DB] = cwd[c*DB +: DB];
            end
            m_rr = (c + 1) % NC;
        end
    endtask

    task automatic compare();
        check("mem_read_valid", 64'(mrv), 64'(e_mrv));
        check("mem_write_valid", 64'(mwv), 64'(e_mwv));
        check("consumer_read_ready", 64'(crr), 64'(e_crr));
        check("consumer_write_ready", 64'(cwr), 64'(e_cwr));
        for (int i = 0; i < NCH; i++) begin
            if (e_mrv[i]) check("mem_read_address", 64'(mra[i*AB +: AB]), 64'(e_mra[i*AB +: AB]));
            if (e_mwv[i]) begin
                check("mem_write_address", 64'(mwa[i*AB +: AB]), 64'(e_mwa[i*AB +: AB]));
                check("mem_write_data", 64'(mwd[i*DB +: DB]), 64'(e_mwd[i*DB +: DB]));
            end
        end
        for (int c = 0; c < NC; c++)
            if (e_crr[c]) check("consumer_read_data", 64'(crd[c*DB +: DB]), 64'(e_crd[c*DB +: DB]));
    endtask

    // Memory responder: random latency per request, occasional stray ready pulses.
    int rlat [NCH];
    int wlat [NCH];

    task automatic drive_mem();
        for (int i = 0; i < NCH; i++) begin
            if (mrr[i]) mrr[i] = 1'b0;
            else if (mrv[i]) begin
                if (rlat[i] == 0) begin mrr[i] = 1'b1; rlat[i] = $urandom_range(0, 3); end
                else rlat[i]--;
            end else mrr[i] = ($urandom_range(0, 15) == 0);
            if (mwr[i]) mwr[i] = 1'b0;
            else if (mwv[i]) begin
                if (wlat[i] == 0) begin mwr[i] = 1'b1; wlat[i] = $urandom_range(0, 3); end
                else wlat[i]--;
            end else mwr[i] = ($urandom_range(0, 15) == 0);
            mrd[i*DB +: DB] = mem_hash(mra[i*AB +: AB]);
        end
    endtask

    int rd_done [NC];
    int wr_done [NC];

    task automatic drive_consumers();
        for (int c = 0; c < NC; c++) begin
            if (crv[c]) begin
                if (crr[c]) begin
                    check("read_data_e2e", 64'(crd[c*DB +: DB]), 64'(mem_hash(cra[c*AB +: AB])));
                    crv[c] = 1'b0;
                    rd_done[c]++;
                end
            end else if (!crr[c] && $urandom_range(0, 1) == 0) begin
                crv[c] = 1'b1;
                cra[c*AB +: AB] = {3'(c), 5'($urandom)};
            end
            if (cwv[c]) begin
                if (cwr[c]) begin
                    cwv[c] = 1'b0;
                    wr_done[c]++;
                end
            end else if (!cwr[c] && $urandom_range(0, 2) == 0) begin
                cwv[c] = 1'b1;
                cwa[c*AB +: AB] = {3'(c), 5'($urandom)};
                cwd[c*DB +: DB] = 8'($urandom);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
        mrr = '0; mwr = '0; mrd = '0;
        for (int i = 0; i < NCH; i++) begin rlat[i] = 1; wlat[i] = 1; end
        for (int c = 0; c < NC; c++) begin rd_done[c] = 0; wr_done[c] = 0; end

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
            if (reset) begin
                check("reset_mem_valid", 64'({mrv, mwv}), 64'd0);
                check("reset_consumer_ready", 64'({crr, cwr}), 64'd0);
            end
            if (cyc == 4) begin
                for (int i = 0; i < NCH; i++)
                    check("contention_owner", 64'(mra[i*AB+5 +: 3]), 64'(i));
            end
            drive_mem();
            if (cyc == 3) begin
                for (int c = 0; c < NC; c++) begin
                    crv[c] = 1'b1;
                    cra[c*AB +: AB] = {3'(c), 5'($urandom)};
                end
            end else if (cyc > 3) begin
                drive_consumers();
            end
            reset = (cyc < 2) || (cyc == 1500) || (cyc == 2700) ||
                    (cyc > 10 && $urandom_range(0, 499) == 0);
        end

        for (int c = 0; c < NC; c++) begin
            check("read_progress", 64'(rd_done[c] > 0), 64'd1);
            check("write_progress", 64'(wr_done[c] > 0), 64'd1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
